// File: rtl/mem_pkg.sv
// Shared buffer-memory definitions: block geometry, the release descriptor
// exchanged with the egress scheduler, and the frame_release FSM encoding.
package mem_pkg;

  localparam int ADDR_W     = 12;
  localparam int NUM_BLOCKS = 4096;

  typedef struct packed {
    logic [ADDR_W-1:0] head;
    logic [ADDR_W:0]   nblocks;
  } rel_desc_t;

  typedef enum logic {
    FR_IDLE = 1'b0,
    FR_WALK = 1'b1
  } fr_state_e;

endpackage

// File: rtl/frame_release_fifo.sv
// Descriptor queue for frame_release (module rel_fifo): synchronous FIFO of
// rel_desc_t with registered full/empty flags derived from the next count.
module rel_fifo
  import mem_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  rel_desc_t wdata_i,
  input  logic      pop_i,
  output rel_desc_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

  rel_desc_t     mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // A push against a registered-full queue is dropped even if a pop happens
  // in the same cycle; the producer only sees the registered flag.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/frame_release.sv
// Frame-release engine: walks a frame's link chain and frees one block per
// cycle. Optional freed-block counter is built when FR_STATS_EN is defined.
module frame_release #(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int QDEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rel_valid_i,
  output logic              rel_ready_o,
  input  logic [ADDR_W-1:0] rel_head_i,
  input  logic [ADDR_W:0]   rel_nblocks_i,
  output logic              link_rd_en_o,
  output logic [ADDR_W-1:0] link_rd_addr_o,
  input  logic [ADDR_W-1:0] link_rd_data_i,
  output logic              free_req_o,
  output logic [ADDR_W-1:0] free_block_idx_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o
`ifdef FR_STATS_EN
  ,
  output logic [31:0]       freed_cnt_o
`endif
);
  import mem_pkg::*;

  localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(NUM_BLOCKS);

  fr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d, cur_sel;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              first_q, first_d;
  logic              err_q, err_d;
  logic              pop;
  logic              fifo_full, fifo_empty;
  rel_desc_t         wr_desc, rd_desc;

  assign wr_desc.head    = rel_head_i;
  assign wr_desc.nblocks = rel_nblocks_i;

  rel_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rel_valid_i),
    .wdata_i (wr_desc),
    .pop_i   (pop),
    .rdata_o (rd_desc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rel_ready_o = !fifo_full;
  assign busy_o      = (state_q == FR_WALK) || !fifo_empty;
  assign err_o       = err_q;

  // The head comes from the descriptor; every later block is the pointer
  // returned by last cycle's link read.
  assign cur_sel = first_q ? cur_q : link_rd_data_i;

  always_comb begin
    state_d          = state_q;
    cur_d            = cur_q;
    rem_d            = rem_q;
    first_d          = first_q;
    err_d            = err_q;
    pop              = 1'b0;
    link_rd_en_o     = 1'b0;
    link_rd_addr_o   = '0;
    free_req_o       = 1'b0;
    free_block_idx_o = '0;
    done_o           = 1'b0;
    case (state_q)
      FR_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = rd_desc.head;
          first_d = 1'b1;
          if (rd_desc.nblocks > MAX_N) begin
            rem_d = MAX_N;
            err_d = 1'b1;
          end else begin
            rem_d = rd_desc.nblocks;
          end
          if (rd_desc.nblocks == '0) begin
            done_o = 1'b1;
          end else begin
            state_d = FR_WALK;
          end
        end
      end
      FR_WALK: begin
        free_req_o       = 1'b1;
        free_block_idx_o = cur_sel;
        first_d          = 1'b0;
        if (rem_q > 1) begin
          link_rd_en_o   = 1'b1;
          link_rd_addr_o = cur_sel;
          rem_d          = rem_q - 1'b1;
        end else begin
          done_o  = 1'b1;
          state_d = FR_IDLE;
        end
      end
      default: state_d = FR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FR_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

`ifdef FR_STATS_EN
  logic [31:0] freed_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      freed_cnt_q <= '0;
    end else if (free_req_o && (freed_cnt_q != '1)) begin
      freed_cnt_q <= freed_cnt_q + 1'b1;
    end
  end

  assign freed_cnt_o = freed_cnt_q;
`endif

endmodule

// File: tb/tb_frame_release.sv
// Directed bench for frame_release: link memory model with one-cycle read
// latency and negedge logs of frees, link reads and done pulses.
module tb_frame_release;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rel_valid_i = 1'b0;
  logic              rel_ready_o;
  logic [ADDR_W-1:0] rel_head_i = '0;
  logic [ADDR_W:0]   rel_nblocks_i = '0;
  logic              link_rd_en_o;
  logic [ADDR_W-1:0] link_rd_addr_o;
  logic [ADDR_W-1:0] link_rd_data_i = '0;
  logic              free_req_o;
  logic [ADDR_W-1:0] free_block_idx_o;
  logic              done_o;
  logic              busy_o;
  logic              err_o;
`ifdef FR_STATS_EN
  logic [31:0]       freed_cnt_o;
`endif

  always #5 clk = ~clk;

  frame_release dut (
    .clk              (clk),
    .rst              (rst),
    .rel_valid_i      (rel_valid_i),
    .rel_ready_o      (rel_ready_o),
    .rel_head_i       (rel_head_i),
    .rel_nblocks_i    (rel_nblocks_i),
    .link_rd_en_o     (link_rd_en_o),
    .link_rd_addr_o   (link_rd_addr_o),
    .link_rd_data_i   (link_rd_data_i),
    .free_req_o       (free_req_o),
    .free_block_idx_o (free_block_idx_o),
    .done_o           (done_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
`ifdef FR_STATS_EN
    ,
    .freed_cnt_o      (freed_cnt_o)
`endif
  );

  logic [ADDR_W-1:0] link_mem [NUM_BLOCKS];

  always @(posedge clk) begin
    if (link_rd_en_o) link_rd_data_i <= link_mem[link_rd_addr_o];
  end

  // cyc counts rising edges; the cycle following edge k is logged as k+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int free_idx[$];
  int free_cyc[$];
  int rd_addr[$];
  int done_cyc[$];

  always @(negedge clk) begin
    if (free_req_o) begin
      free_idx.push_back(int'(free_block_idx_o));
      free_cyc.push_back(cyc + 1);
    end
    if (link_rd_en_o) rd_addr.push_back(int'(link_rd_addr_o));
    if (done_o) done_cyc.push_back(cyc + 1);
  end

  int total = 0;
  int bad   = 0;

  task automatic clear_logs();
    free_idx.delete();
    free_cyc.delete();
    rd_addr.delete();
    done_cyc.delete();
  endtask

  task automatic link_default();
    for (int i = 0; i < NUM_BLOCKS; i++) link_mem[i] = ADDR_W'((i + 1) % NUM_BLOCKS);
  endtask

  task automatic push_desc(input int head, input int n, output int t);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rel_ready_o && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (rel_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL push_ready_wait ready=%b expected 1", rel_ready_o);
    end
    rel_valid_i   = 1'b1;
    rel_head_i    = head[ADDR_W-1:0];
    rel_nblocks_i = n[ADDR_W:0];
    @(posedge clk);
    #1;
    t = cyc;
    rel_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_o && guard < max_cyc) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_reset();
    logic [5+2*ADDR_W:0] obs, exp;
    @(negedge clk);
    obs = {rel_ready_o, link_rd_en_o, free_req_o, done_o, busy_o, err_o,
           link_rd_addr_o, free_block_idx_o};
    exp = '0;
    exp[5+2*ADDR_W] = 1'b1;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_outputs got=%h expected=%h", obs, exp);
    end
`ifdef FR_STATS_EN
    total++;
    if (freed_cnt_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_freed_cnt got=%0d expected 0", freed_cnt_o);
    end
`endif
  endtask

  task automatic test_single();
    int t;
    clear_logs();
    push_desc(2048, 1, t);
    wait_idle(50);
    total++;
    if (free_idx.size() != 1 || free_idx[0] != 2048 || free_cyc[0] != t + 2) begin
      bad++;
      $display("FAIL single_free n=%0d idx=%0d cyc=%0d expected n=1 idx=2048 cyc=%0d",
               free_idx.size(), free_idx.size() > 0 ? free_idx[0] : -1,
               free_cyc.size() > 0 ? free_cyc[0] : -1, t + 2);
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 2) begin
      bad++;
      $display("FAIL single_done n=%0d expected one pulse at %0d", done_cyc.size(), t + 2);
    end
    total++;
    if (rd_addr.size() != 0) begin
      bad++;
      $display("FAIL single_no_read reads=%0d expected 0", rd_addr.size());
    end
  endtask

  task automatic test_chain();
    int t;
    int exp_idx[3] = '{5, 17, 9};
    clear_logs();
    link_mem[5]  = ADDR_W'(17);
    link_mem[17] = ADDR_W'(9);
    push_desc(5, 3, t);
    wait_idle(50);
    total++;
    if (free_idx.size() != 3) begin
      bad++;
      $display("FAIL chain_free_count got=%0d expected 3", free_idx.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= free_idx.size() || free_idx[i] != exp_idx[i] || free_cyc[i] != t + 2 + i) begin
        bad++;
        $display("FAIL chain_free[%0d] idx=%0d cyc=%0d expected idx=%0d cyc=%0d", i,
                 i < free_idx.size() ? free_idx[i] : -1,
                 i < free_cyc.size() ? free_cyc[i] : -1, exp_idx[i], t + 2 + i);
      end
    end
    total++;
    if (rd_addr.size() != 2 || rd_addr[0] != 5 || rd_addr[1] != 17) begin
      bad++;
      $display("FAIL chain_reads n=%0d expected addresses 5,17", rd_addr.size());
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 4) begin
      bad++;
      $display("FAIL chain_done n=%0d expected one pulse at %0d", done_cyc.size(), t + 4);
    end
    link_default();
  endtask

  task automatic test_back_to_back();
    int ta, tb;
    int exp_idx[4] = '{100, 101, 200, 201};
    int exp_off[4] = '{2, 3, 5, 6};
    clear_logs();
    push_desc(100, 2, ta);
    push_desc(200, 2, tb);
    wait_idle(50);
    total++;
    if (tb != ta + 1) begin
      bad++;
      $display("FAIL b2b_accept second=%0d expected %0d", tb, ta + 1);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= free_idx.size() || free_idx[i] != exp_idx[i] || free_cyc[i] != ta + exp_off[i]) begin
        bad++;
        $display("FAIL b2b_free[%0d] idx=%0d cyc=%0d expected idx=%0d cyc=%0d", i,
                 i < free_idx.size() ? free_idx[i] : -1,
                 i < free_cyc.size() ? free_cyc[i] : -1, exp_idx[i], ta + exp_off[i]);
      end
    end
    total++;
    if (done_cyc.size() != 2 || done_cyc[0] != ta + 3 || done_cyc[1] != ta + 6) begin
      bad++;
      $display("FAIL b2b_done n=%0d expected pulses at %0d,%0d", done_cyc.size(), ta + 3, ta + 6);
    end
  endtask

  task automatic test_queue_full();
    int tl, td, t5, dcyc;
    clear_logs();
    push_desc(0, 64, tl);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) push_desc(300 + i, 1, td);
    @(negedge clk);
    total++;
    if (rel_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%b expected 0", rel_ready_o);
    end
    push_desc(304, 1, t5);
    dcyc = done_cyc.size() > 0 ? done_cyc[0] : -1;
    total++;
    if (t5 != tl + 65 + 2) begin
      bad++;
      $display("FAIL full_fifth_accept got=%0d expected %0d (long done %0d)", t5, tl + 67, dcyc);
    end
    wait_idle(200);
    total++;
    if (free_idx.size() != 69 || done_cyc.size() != 6) begin
      bad++;
      $display("FAIL full_totals frees=%0d dones=%0d expected 69 and 6", free_idx.size(), done_cyc.size());
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (64 + i >= free_idx.size() || free_idx[64 + i] != 300 + i) begin
        bad++;
        $display("FAIL full_order[%0d] idx=%0d expected %0d", i,
                 64 + i < free_idx.size() ? free_idx[64 + i] : -1, 300 + i);
      end
    end
  endtask

  task automatic test_zero_oversize();
    int t;
    clear_logs();
    push_desc(7, 0, t);
    wait_idle(50);
    total++;
    if (free_idx.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != t + 1) begin
      bad++;
      $display("FAIL zero_len frees=%0d dones=%0d expected 0 frees, done at %0d",
               free_idx.size(), done_cyc.size(), t + 1);
    end
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_err got=%b expected 0", err_o);
    end
    clear_logs();
    push_desc(0, NUM_BLOCKS + 1, t);
    wait_idle(NUM_BLOCKS + 100);
    total++;
    if (free_idx.size() != NUM_BLOCKS || free_idx[0] != 0 || free_idx[NUM_BLOCKS-1] != NUM_BLOCKS - 1) begin
      bad++;
      $display("FAIL oversize_frees n=%0d expected %0d covering 0..%0d",
               free_idx.size(), NUM_BLOCKS, NUM_BLOCKS - 1);
    end
    total++;
    if (rd_addr.size() != NUM_BLOCKS - 1 || done_cyc.size() != 1) begin
      bad++;
      $display("FAIL oversize_reads reads=%0d dones=%0d expected %0d and 1",
               rd_addr.size(), done_cyc.size(), NUM_BLOCKS - 1);
    end
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL oversize_err got=%b expected 1", err_o);
    end
  endtask

  task automatic test_reset_mid_walk();
    int ta, tb;
    logic [5+2*ADDR_W:0] obs, exp;
    clear_logs();
    push_desc(50, 10, ta);
    push_desc(400, 3, tb);
    repeat (3) @(negedge clk);
    total++;
    if (free_req_o !== 1'b1 || free_block_idx_o !== ADDR_W'(52)) begin
      bad++;
      $display("FAIL midrst_third_free req=%b idx=%0d expected 1 and 52", free_req_o, free_block_idx_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    obs = {rel_ready_o, link_rd_en_o, free_req_o, done_o, busy_o, err_o,
           link_rd_addr_o, free_block_idx_o};
    exp = '0;
    exp[5+2*ADDR_W] = 1'b1;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL midrst_outputs got=%h expected=%h", obs, exp);
    end
`ifdef FR_STATS_EN
    total++;
    if (freed_cnt_o !== 32'd0) begin
      bad++;
      $display("FAIL midrst_freed_cnt got=%0d expected 0", freed_cnt_o);
    end
`endif
    rst = 1'b0;
    clear_logs();
    repeat (15) @(negedge clk);
    total++;
    if (free_idx.size() != 0 || done_cyc.size() != 0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flushed frees=%0d dones=%0d busy=%b expected 0,0,0",
               free_idx.size(), done_cyc.size(), busy_o);
    end
  endtask

  initial begin
    link_default();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_chain();
    test_back_to_back();
    test_queue_full();
    test_zero_oversize();
    test_reset_mid_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
